// File: rtl/axi_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_if
// Bundle of the requester-side and AXI-side signals of axi_rd_arbiter.
//   requester side : req_valid, req_addr, req_len (packed, requester i at
//                    slice i), req_ready (one-hot accept strobe)
//   AR channel     : arvalid, arid, araddr, arlen, arready
//   R monitor      : rvalid, rready, rlast, rid, r_owner, r_owner_valid
//   status         : outstanding_cnt (number of allocated IDs)
// Modports:
//   master : the arbiter's view (drives req_ready, AR channel, R monitor outputs)
//   slave  : the environment's view (requesters, AXI slave, R channel)
// -----------------------------------------------------------------------------
interface axi_rd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*8-1:0]          req_len;
    logic [NUM_REQ-1:0]            req_ready;

    logic                          arvalid;
    logic [ID_WIDTH-1:0]           arid;
    logic [ADDR_WIDTH-1:0]         araddr;
    logic [7:0]                    arlen;
    logic                          arready;

    logic                          rvalid;
    logic                          rready;
    logic                          rlast;
    logic [ID_WIDTH-1:0]           rid;
    logic [OW-1:0]                 r_owner;
    logic                          r_owner_valid;

    logic [ID_WIDTH:0]             outstanding_cnt;

    modport master (
        input  req_valid, req_addr, req_len, arready,
        input  rvalid, rready, rlast, rid,
        output req_ready, arvalid, arid, araddr, arlen,
        output r_owner, r_owner_valid, outstanding_cnt
    );

    modport slave (
        output req_valid, req_addr, req_len, arready,
        output rvalid, rready, rlast, rid,
        input  req_ready, arvalid, arid, araddr, arlen,
        input  r_owner, r_owner_valid, outstanding_cnt
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Round-robin arbiter sharing one AXI AR channel among NUM_REQ requesters.
// Allocates the lowest free ARID from a busy bitmap, drives the AR handshake,
// and monitors the R channel to route beats to their owner and release IDs
// on the last beat.
// Ports:
//   clk      : clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : axi_rd_arbiter_if.master (requester, AR, R-monitor, status)
//   rd_err   : sticky error on R beat with unallocated RID; exists only when
//              AXI_RD_ARB_ERR_EN is defined
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request and a free ID; grant issued here
// SEND  | arvalid high, AR fields held until arready
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    axi_rd_arbiter_if.master  bus
`ifdef AXI_RD_ARB_ERR_EN
    ,
    output logic              rd_err
`endif
);
    localparam int ID_COUNT = 1 << ID_WIDTH;
    localparam int OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [OW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_COUNT-1:0]   busy_q, busy_d;
    logic [OW-1:0]         owner_q [ID_COUNT];
    logic [ID_WIDTH-1:0]   arid_q, arid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [ID_WIDTH:0]     cnt_q, cnt_d;

    logic                  free_found;
    logic [ID_WIDTH-1:0]   free_id;
    logic                  grant_found;
    logic [OW-1:0]         grant_idx;
    logic                  alloc;
    logic                  rel;
    logic [NUM_REQ-1:0]    req_ready_c;

    // Lowest-index free ID; descending scan so the smallest index wins.
    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        for (int i = ID_COUNT - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_id    = ID_WIDTH'(i);
            end
        end
    end

    // First valid requester at or after rr_ptr with wrap; descending scan so
    // the requester closest to rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = OW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Release uses the pre-edge bitmap, so beats for unallocated IDs are ignored.
    assign rel = bus.rvalid & bus.rready & bus.rlast & busy_q[bus.rid];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        alloc       = 1'b0;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (grant_found && free_found) begin
                    alloc                  = 1'b1;
                    req_ready_c[grant_idx] = 1'b1;
                    arid_d                 = free_id;
                    araddr_d               = bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    arlen_d                = bus.req_len[grant_idx*8 +: 8];
                    rr_ptr_d               = (grant_idx == OW'(NUM_REQ - 1)) ? '0 : grant_idx + OW'(1);
                    state_d                = SEND;
                end
            end
            SEND: begin
                if (bus.arready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // free_id is never busy, so it can never collide with the released ID.
    always_comb begin
        busy_d = busy_q;
        if (rel) begin
            busy_d[bus.rid] = 1'b0;
        end
        if (alloc) begin
            busy_d[free_id] = 1'b1;
        end
        cnt_d = cnt_q;
        if (alloc && !rel) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!alloc && rel) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            busy_q   <= '0;
            arid_q   <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < ID_COUNT; i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            arid_q   <= arid_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            cnt_q    <= cnt_d;
            if (alloc) begin
                owner_q[free_id] <= grant_idx;
            end
        end
    end

`ifdef AXI_RD_ARB_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (bus.rvalid && bus.rready && !busy_q[bus.rid]) begin
            err_q <= 1'b1;
        end
    end

    assign rd_err = err_q;
`endif

    assign bus.req_ready       = req_ready_c;
    assign bus.arvalid         = (state_q == SEND);
    assign bus.arid            = arid_q;
    assign bus.araddr          = araddr_q;
    assign bus.arlen           = arlen_q;
    assign bus.r_owner         = owner_q[bus.rid];
    assign bus.r_owner_valid   = bus.rvalid & busy_q[bus.rid];
    assign bus.outstanding_cnt = cnt_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Self-checking bench for axi_rd_arbiter. A transaction-level model (busy set,
// owner table, one pending AR record, round-robin pointer) predicts outputs
// every cycle; directed scenarios add literal expectations.
// Build with AXI_RD_ARB_ERR_EN defined to also cover rd_err.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;
    localparam int NR = 4;
    localparam int AW = 16;
    localparam int IW = 4;
    localparam int NID = 1 << IW;

    logic clk;
    logic reset_n;
`ifdef AXI_RD_ARB_ERR_EN
    logic rd_err;
`endif

    axi_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi_rd_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef AXI_RD_ARB_ERR_EN
        ,
        .rd_err  (rd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- model state ----------------
    logic [NID-1:0] m_busy;
    int             m_owner [NID];
    bit             m_pend;
    int             m_arid, m_addr, m_len;
    int             m_ptr;
    bit             m_err;
    int             mg, fid;
    logic [NR-1:0]  exp_rdy;

    int g_log[$];
    int g_cyc[$];
    int id_log[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            m_busy = '0;
            m_pend = 1'b0;
            m_ptr  = 0;
            m_err  = 1'b0;
            m_arid = 0;
            m_addr = 0;
            m_len  = 0;
            chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_arvalid",   32'(bus.arvalid),   32'd0);
            chk("rst_arid",      32'(bus.arid),      32'd0);
            chk("rst_araddr",    32'(bus.araddr),    32'd0);
            chk("rst_arlen",     32'(bus.arlen),     32'd0);
            chk("rst_cnt",       32'(bus.outstanding_cnt), 32'd0);
`ifdef AXI_RD_ARB_ERR_EN
            chk("rst_rd_err",    32'(rd_err),        32'd0);
`endif
        end else begin
            // expected grant: arbiter idle, some request, some free ID
            mg = -1;
            if (!m_pend && $countones(m_busy) < NID) begin
                for (int k = 0; k < NR; k++) begin
                    if (mg < 0 && bus.req_valid[(m_ptr + k) % NR]) mg = (m_ptr + k) % NR;
                end
            end
            exp_rdy = (mg >= 0) ? NR'(1 << mg) : '0;
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            chk("arvalid", 32'(bus.arvalid), 32'(m_pend));
            if (m_pend) begin
                chk("arid",   32'(bus.arid),   32'(m_arid));
                chk("araddr", 32'(bus.araddr), 32'(m_addr));
                chk("arlen",  32'(bus.arlen),  32'(m_len));
            end
            chk("outstanding_cnt", 32'(bus.outstanding_cnt), 32'($countones(m_busy)));
            chk("r_owner_valid", 32'(bus.r_owner_valid), 32'(bus.rvalid && m_busy[bus.rid]));
            if (bus.rvalid && m_busy[bus.rid]) begin
                chk("r_owner", 32'(bus.r_owner), 32'(m_owner[bus.rid]));
            end
`ifdef AXI_RD_ARB_ERR_EN
            chk("rd_err", 32'(rd_err), 32'(m_err));
`endif
            // observed-behaviour logs for the directed checks
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ready[i]) begin
                    g_log.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
            if (bus.arvalid && bus.arready) id_log.push_back(int'(bus.arid));

            // advance model: allocation sees only the pre-edge busy set
            fid = -1;
            for (int i = NID - 1; i >= 0; i--) if (!m_busy[i]) fid = i;
            if (m_pend && bus.arready) m_pend = 1'b0;
            if (bus.rvalid && bus.rready) begin
                if (m_busy[bus.rid]) begin
                    if (bus.rlast) m_busy[bus.rid] = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (mg >= 0) begin
                m_pend        = 1'b1;
                m_arid        = fid;
                m_addr        = int'(bus.req_addr[mg*AW +: AW]);
                m_len         = int'(bus.req_len[mg*8 +: 8]);
                m_owner[fid]  = mg;
                m_busy[fid]   = 1'b1;
                m_ptr         = (mg + 1) % NR;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r);
        bus.req_valid = NR'(1 << r);
        tick();
        bus.req_valid = '0;
        tick();
    endtask

    task automatic clear_logs();
        g_log.delete();
        g_cyc.delete();
        id_log.delete();
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        bus.rready    = 1'b0;
        bus.rlast     = 1'b0;
        bus.rid       = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW] = AW'(16'h1000 + i);
            bus.req_len[i*8 +: 8]    = 8'(i);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // ---- single request ----
        clear_logs();
        bus.req_addr[2*AW +: AW] = 16'h1234;
        bus.req_len[2*8 +: 8]    = 8'd3;
        bus.arready   = 1'b1;
        bus.req_valid = 4'b0100;
        #2 chk("single_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        #2;
        chk("single_arvalid", 32'(bus.arvalid), 32'd1);
        chk("single_arid",    32'(bus.arid),    32'd0);
        chk("single_araddr",  32'(bus.araddr),  32'h1234);
        chk("single_arlen",   32'(bus.arlen),   32'd3);
        chk("single_cnt",     32'(bus.outstanding_cnt), 32'd1);
        tick();
        #2 chk("single_arvalid_drop", 32'(bus.arvalid), 32'd0);
        chk("single_grant_count", 32'(g_log.size()), 32'd1);
        bus.req_addr[2*AW +: AW] = 16'h1002;
        bus.req_len[2*8 +: 8]    = 8'd2;

        // ---- round robin from reset ----
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_logs();
        bus.req_valid = 4'b1111;
        repeat (9) tick();
        bus.req_valid = '0;
        tick();
        tick();
        chk("rr_grants", 32'(g_log.size()), 32'd5);
        chk("rr_ids",    32'(id_log.size()), 32'd5);
        if (g_log.size() == 5 && id_log.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("rr_order", 32'(g_log[i]), 32'(i % NR));
                chk("rr_arid",  32'(id_log[i]), 32'(i));
                if (i > 0) chk("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd2);
            end
        end

        // ---- backpressure: ptr now 1, IDs 0..4 busy ----
        bus.arready   = 1'b0;
        bus.req_valid = 4'b1000;
        #2 chk("bp_grant", 32'(bus.req_ready), 32'h8);
        for (int i = 0; i < 5; i++) begin
            tick();
            #2;
            chk("bp_arvalid", 32'(bus.arvalid), 32'd1);
            chk("bp_arid",    32'(bus.arid),    32'd5);
            chk("bp_araddr",  32'(bus.araddr),  32'h1003);
            chk("bp_arlen",   32'(bus.arlen),   32'd3);
            chk("bp_noready", 32'(bus.req_ready), 32'd0);
        end
        tick();
        bus.arready = 1'b1;
        #2 chk("bp_hs_noready", 32'(bus.req_ready), 32'd0);
        tick();
        #2 chk("bp_after_hs_ready", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        tick();

        // ---- ID exhaustion and refill: 7 busy, need 9 more ----
        bus.req_valid = 4'b1111;
        repeat (24) tick();
        #2;
        chk("exh_cnt",      32'(bus.outstanding_cnt), 32'd16);
        chk("exh_noready",  32'(bus.req_ready), 32'd0);
        chk("exh_model_cnt", 32'($countones(m_busy)), 32'd16);
        bus.rvalid = 1'b1;
        bus.rready = 1'b1;
        bus.rlast  = 1'b1;
        bus.rid    = 4'd5;
        #1;
        chk("exh_rel_owner",  32'(bus.r_owner),       32'd3);
        chk("exh_rel_ovalid", 32'(bus.r_owner_valid), 32'd1);
        chk("exh_rel_noready", 32'(bus.req_ready),    32'd0);
        tick();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #2;
        chk("exh_cnt_15",   32'(bus.outstanding_cnt), 32'd15);
        chk("exh_refill_ready", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        #2;
        chk("exh_refill_arid", 32'(bus.arid), 32'd5);
        chk("exh_refill_cnt",  32'(bus.outstanding_cnt), 32'd16);
        tick();

        // ---- reset while arvalid is high ----
        bus.arready   = 1'b0;
        tick();
        reset_n = 1'b0;
        #2;
        chk("mid_rst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("mid_rst_cnt",     32'(bus.outstanding_cnt), 32'd0);
        tick();
        reset_n     = 1'b1;
        bus.arready = 1'b1;

        // ---- R routing: IDs 0..2 to req 0, ID 3 to req 1 ----
        issue(0);
        issue(0);
        issue(0);
        issue(1);
        bus.rvalid = 1'b1;
        bus.rready = 1'b0;
        bus.rlast  = 1'b1;
        bus.rid    = 4'd3;
        #2 chk("rt_nordy_owner", 32'(bus.r_owner), 32'd1);
        tick();
        bus.rready = 1'b1;
        bus.rlast  = 1'b0;
        #2;
        chk("rt_beat0_owner",  32'(bus.r_owner),       32'd1);
        chk("rt_beat0_ovalid", 32'(bus.r_owner_valid), 32'd1);
        chk("rt_beat0_cnt",    32'(bus.outstanding_cnt), 32'd4);
        tick();
        bus.rlast = 1'b1;
        #2;
        chk("rt_last_owner",  32'(bus.r_owner),       32'd1);
        chk("rt_last_ovalid", 32'(bus.r_owner_valid), 32'd1);
        chk("rt_last_cnt",    32'(bus.outstanding_cnt), 32'd4);
        tick();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #2 chk("rt_freed_cnt", 32'(bus.outstanding_cnt), 32'd3);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        #2 chk("rt_reuse_arid", 32'(bus.arid), 32'd3);
        tick();

        // ---- beat for unallocated ID 9 ----
        bus.rvalid = 1'b1;
        bus.rready = 1'b1;
        bus.rlast  = 1'b1;
        bus.rid    = 4'd9;
        #2 chk("err_ovalid", 32'(bus.r_owner_valid), 32'd0);
        tick();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #2 chk("err_cnt", 32'(bus.outstanding_cnt), 32'd4);
`ifdef AXI_RD_ARB_ERR_EN
        chk("err_set", 32'(rd_err), 32'd1);
        repeat (3) tick();
        chk("err_sticky", 32'(rd_err), 32'd1);
        reset_n = 1'b0;
        #2 chk("err_cleared", 32'(rd_err), 32'd0);
        tick();
        reset_n = 1'b1;
`endif
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
